// File: rtl/render_pkg.sv
// Shared constants and FSM state encoding for the rectangle fill sequencer.
package render_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOR_W  = 3;
  localparam int ADDR_W   = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/rect_coord_stepper.sv
// Walks col/row/k across a rectangle and forms the framebuffer address.
// Optional screen clipping flag is enabled by defining CLIP_EN.
module rect_coord_stepper
  import render_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [X_W-1:0]    x0,
  input  logic [Y_W-1:0]    y0,
  input  logic [X_W-1:0]    w,
  output logic [ADDR_W-1:0] k,
  output logic [ADDR_W-1:0] addr,
  output logic              on_screen
);

  logic [X_W-1:0]    col_q, col_d;
  logic [Y_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] xs, ys;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    k_d   = k_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
      k_d   = '0;
    end else if (step) begin
      k_d = k_q + ADDR_W'(1);
      if (col_q == w - X_W'(1)) begin
        col_d = '0;
        row_d = row_q + Y_W'(1);
      end else begin
        col_d = col_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      k_q   <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      k_q   <= k_d;
    end
  end

  // Screen coordinates are widened before the multiply so wrapping happens only at ADDR_W.
  always_comb begin
    xs   = ADDR_W'(x0) + ADDR_W'(col_q);
    ys   = ADDR_W'(y0) + ADDR_W'(row_q);
    addr = ys * ADDR_W'(SCREEN_W) + xs;
`ifdef CLIP_EN
    on_screen = (xs < ADDR_W'(SCREEN_W)) && (ys < ADDR_W'(SCREEN_H));
`else
    on_screen = 1'b1;
`endif
  end

  assign k = k_q;

endmodule

// File: rtl/rect_fill_sequencer.sv
// Accepts a rectangle fill, arms the pixel counter and turns its index stream into
// framebuffer writes. Define CLIP_EN to suppress writes for off-screen pixels.
module rect_fill_sequencer
  import render_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [X_W-1:0]     req_x,
  input  logic [Y_W-1:0]     req_y,
  input  logic [X_W-1:0]     req_w,
  input  logic [Y_W-1:0]     req_h,
  input  logic [COLOR_W-1:0] req_color,
  output logic               start_count,
  output logic [ADDR_W-1:0]  limit,
  input  logic [ADDR_W-1:0]  cnt_idx,
  input  logic               cnt_done,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               busy,
  output logic               err
);

  state_e             state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [X_W-1:0]     w_q, w_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [ADDR_W-1:0]  limit_q, limit_d;
  logic               err_q, err_d;
  logic               drain_q, drain_d;

  logic [ADDR_W-1:0]  k;
  logic [ADDR_W-1:0]  pix_addr;
  logic               on_screen;
  logic               running;

  assign running = (state_q == RUN);

  rect_coord_stepper u_stepper (
    .clk       (clk),
    .reset     (reset),
    .clear     (!running),
    .step      (running),
    .x0        (x_q),
    .y0        (y_q),
    .w         (w_q),
    .k         (k),
    .addr      (pix_addr),
    .on_screen (on_screen)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    color_d = color_q;
    limit_d = limit_q;
    err_d   = err_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          x_d     = req_x;
          y_d     = req_y;
          w_d     = req_w;
          color_d = req_color;
          limit_d = ADDR_W'(req_w) * ADDR_W'(req_h);
          err_d   = 1'b0;
          if (req_w != '0 && req_h != '0) begin
            state_d = ARM;
          end
        end
      end
      ARM: begin
        state_d = RUN;
      end
      RUN: begin
        if (cnt_idx != k) begin
          err_d = 1'b1;
        end
        // An early finish from the counter abandons the rectangle.
        if (cnt_done) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (k == limit_q - ADDR_W'(1)) begin
          drain_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_done) begin
          state_d = IDLE;
        end else if (drain_q) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      color_q <= '0;
      limit_q <= '0;
      err_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      color_q <= color_d;
      limit_q <= limit_d;
      err_q   <= err_d;
      drain_q <= drain_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign start_count = (state_q == ARM);
  assign limit       = limit_q;
  assign err         = err_q;
  assign fb_we       = running && on_screen;
  assign fb_addr     = running ? pix_addr : '0;
  assign fb_data     = running ? color_q : '0;

endmodule

// File: tb/tb_rect_fill_sequencer.sv
// Scoreboard bench for rect_fill_sequencer with a behavioural index counter.
module tb_rect_fill_sequencer;
  import render_pkg::*;

  logic               clk;
  logic               reset;
  logic               req_valid;
  logic               req_ready;
  logic [X_W-1:0]     req_x;
  logic [Y_W-1:0]     req_y;
  logic [X_W-1:0]     req_w;
  logic [Y_W-1:0]     req_h;
  logic [COLOR_W-1:0] req_color;
  logic               start_count;
  logic [ADDR_W-1:0]  limit;
  logic [ADDR_W-1:0]  cnt_idx;
  logic               cnt_done;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               busy;
  logic               err;

  int checks   = 0;
  int failures = 0;
  bit skip_mode = 0;
  logic [ADDR_W+COLOR_W-1:0] exp_q[$];

  rect_fill_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_w       (req_w),
    .req_h       (req_h),
    .req_color   (req_color),
    .start_count (start_count),
    .limit       (limit),
    .cnt_idx     (cnt_idx),
    .cnt_done    (cnt_done),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input int addr, input int data);
    exp_q.push_back({ADDR_W'(addr), COLOR_W'(data)});
  endtask

  task automatic applyStimulus(input int x, input int y, input int w, input int h, input int c);
    @(negedge clk);
    checkOutput("ready_before_req", 32'(req_ready), 32'd1);
    req_x     = X_W'(x);
    req_y     = Y_W'(y);
    req_w     = X_W'(w);
    req_h     = Y_W'(h);
    req_color = COLOR_W'(c);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    checkOutput({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Behavioural counter: idx 0 the cycle after start, then one index per cycle, then a done pulse.
  initial begin
    int n;
    bit aborted;
    cnt_idx  = '0;
    cnt_done = 1'b0;
    forever begin
      @(negedge clk);
      if (start_count) begin
        n = int'(limit);
        aborted = 0;
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          #1;
          if (reset) begin
            aborted = 1;
            break;
          end
          cnt_idx = (skip_mode && i == 3) ? ADDR_W'(2) : ADDR_W'(i);
        end
        if (!aborted) begin
          @(posedge clk);
          #1 cnt_done = 1'b1;
          @(posedge clk);
          #1 cnt_done = 1'b0;
        end
        cnt_idx = '0;
      end
    end
  end

  // Monitor: every framebuffer write is matched against the oldest expected write.
  initial begin
    logic [ADDR_W+COLOR_W-1:0] e;
    forever begin
      @(negedge clk);
      if (fb_we) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write_addr", 32'(fb_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_addr", 32'(fb_addr), 32'(e[ADDR_W+COLOR_W-1:COLOR_W]));
          checkOutput("wr_data", 32'(fb_data), 32'(e[COLOR_W-1:0]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit saw_start;
    bit lost_ready;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_w     = '0;
    req_h     = '0;
    req_color = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_start", 32'(start_count), 32'd0);
    checkOutput("rst_limit", 32'(limit), 32'd0);
    checkOutput("rst_we", 32'(fb_we), 32'd0);
    checkOutput("rst_addr", 32'(fb_addr), 32'd0);
    checkOutput("rst_data", 32'(fb_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // Basic 3x2 rectangle.
    expectWrite(1610, 5); expectWrite(1611, 5); expectWrite(1612, 5);
    expectWrite(1930, 5); expectWrite(1931, 5); expectWrite(1932, 5);
    applyStimulus(10, 5, 3, 2, 5);
    @(negedge clk);
    checkOutput("t1_start", 32'(start_count), 32'd1);
    checkOutput("t1_limit", 32'(limit), 32'd6);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    waitIdle("t1");
    checkOutput("t1_err", 32'(err), 32'd0);
    checkOutput("t1_pending", 32'(exp_q.size()), 32'd0);

    // Zero-area request.
    applyStimulus(4, 4, 0, 7, 3);
    saw_start  = 0;
    lost_ready = 0;
    repeat (5) begin
      @(negedge clk);
      if (start_count) saw_start = 1;
      if (!req_ready) lost_ready = 1;
    end
    checkOutput("t2_no_start", 32'(saw_start), 32'd0);
    checkOutput("t2_ready_held", 32'(lost_ready), 32'd0);

    // Single pixel at the bottom-right corner.
    expectWrite(76799, 1);
    applyStimulus(319, 239, 1, 1, 1);
    waitIdle("t3");
    checkOutput("t3_err", 32'(err), 32'd0);
    checkOutput("t3_pending", 32'(exp_q.size()), 32'd0);

    // Row crossing the right screen edge.
    expectWrite(318, 7); expectWrite(319, 7);
`ifndef CLIP_EN
    expectWrite(320, 7); expectWrite(321, 7);
`endif
    applyStimulus(318, 0, 4, 1, 7);
    waitIdle("t4");
    checkOutput("t4_err", 32'(err), 32'd0);
    checkOutput("t4_pending", 32'(exp_q.size()), 32'd0);

    // Counter repeats idx 2 in place of idx 3.
    skip_mode = 1;
    for (int i = 0; i < 5; i++) expectWrite(i, 2);
    applyStimulus(0, 0, 5, 1, 2);
    waitIdle("t5");
    skip_mode = 0;
    checkOutput("t5_err_set", 32'(err), 32'd1);
    checkOutput("t5_pending", 32'(exp_q.size()), 32'd0);
    expectWrite(650, 4); expectWrite(651, 4);
    applyStimulus(10, 2, 2, 1, 4);
    waitIdle("t5b");
    checkOutput("t5_err_cleared", 32'(err), 32'd0);

    // Reset in the middle of a rectangle.
    expectWrite(0, 3); expectWrite(1, 3);
    applyStimulus(0, 0, 4, 2, 3);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_start", 32'(start_count), 32'd0);
    checkOutput("t6_we", 32'(fb_we), 32'd0);
    checkOutput("t6_addr", 32'(fb_addr), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_ready", 32'(req_ready), 32'd1);
    checkOutput("t6_limit", 32'(limit), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("t6_pending", 32'(exp_q.size()), 32'd0);
    expectWrite(321, 6); expectWrite(322, 6); expectWrite(641, 6); expectWrite(642, 6);
    applyStimulus(1, 1, 2, 2, 6);
    waitIdle("t6b");
    checkOutput("t6b_err", 32'(err), 32'd0);
    checkOutput("t6b_pending", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
